// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM wrapper: byte-enable writes, 1/2-cycle reads,
// same-address collision counting. Define SRAM_BYPASS_EN for write-first p1 data.
module sram_1rw1r_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [DATA_W/8-1:0] p0_be,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic [ADDR_W-1:0]   p1_addr,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  input  logic                coll_clr,
  output logic [15:0]         coll_cnt
);

  localparam int NB = DATA_W / 8;

  initial begin
    if (RD_LAT != 1 && RD_LAT != 2)
      $error("sram_1rw1r_param: RD_LAT must be 1 or 2");
    if (DATA_W % 8 != 0)
      $error("sram_1rw1r_param: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              p0_in;
  logic              p1_in;
  logic              p0_wr;
  logic              p0_rd;
  logic              coll;
  logic [DATA_W-1:0] p0_word;
  logic [DATA_W-1:0] p1_word;

  assign p0_in = 32'(p0_addr) < DEPTH;
  assign p1_in = 32'(p1_addr) < DEPTH;
  assign p0_wr = p0_req & p0_we & p0_in;
  assign p0_rd = p0_req & ~p0_we;
  assign coll  = p0_wr & p1_req & p1_in
               & (p0_addr == p1_addr) & (|p0_be);

  // Array has no reset so contents survive RESET.
  always_ff @(posedge CLK) begin
    if (p0_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (p0_be[i])
          mem[p0_addr][i*8 +: 8] <= p0_wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    p0_word = '0;
    if (p0_in)
      p0_word = mem[p0_addr];
  end

  always_comb begin
    p1_word = '0;
    if (p1_in)
      p1_word = mem[p1_addr];
`ifdef SRAM_BYPASS_EN
    if (coll) begin
      for (int i = 0; i < NB; i++) begin
        if (p0_be[i])
          p1_word[i*8 +: 8] = p0_wdata[i*8 +: 8];
      end
    end
`endif
  end

  logic              p0_v1;
  logic              p1_v1;
  logic [DATA_W-1:0] p0_d1;
  logic [DATA_W-1:0] p1_d1;

  // Data registers only load on a read so rdata holds between reads.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      p0_v1 <= 1'b0;
      p1_v1 <= 1'b0;
      p0_d1 <= '0;
      p1_d1 <= '0;
    end else begin
      p0_v1 <= p0_rd;
      p1_v1 <= p1_req;
      if (p0_rd)
        p0_d1 <= p0_word;
      if (p1_req)
        p1_d1 <= p1_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              p0_v2;
      logic              p1_v2;
      logic [DATA_W-1:0] p0_d2;
      logic [DATA_W-1:0] p1_d2;

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          p0_v2 <= 1'b0;
          p1_v2 <= 1'b0;
          p0_d2 <= '0;
          p1_d2 <= '0;
        end else begin
          p0_v2 <= p0_v1;
          p1_v2 <= p1_v1;
          if (p0_v1)
            p0_d2 <= p0_d1;
          if (p1_v1)
            p1_d2 <= p1_d1;
        end
      end

      assign p0_rvalid = p0_v2;
      assign p0_rdata  = p0_d2;
      assign p1_rvalid = p1_v2;
      assign p1_rdata  = p1_d2;
    end else begin : g_lat1
      assign p0_rvalid = p0_v1;
      assign p0_rdata  = p0_d1;
      assign p1_rvalid = p1_v1;
      assign p1_rdata  = p1_d1;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      coll_cnt <= '0;
    else if (coll_clr)
      coll_cnt <= '0;
    else if (coll && coll_cnt != 16'hFFFF)
      coll_cnt <= coll_cnt + 16'd1;
  end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench: u1 is RD_LAT=1/DEPTH=200, u2 is RD_LAT=2/DEPTH=256,
// both driven by the same stimulus.
module tb_sram_1rw1r_param;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        p0_req;
  logic        p0_we;
  logic [3:0]  p0_be;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p1_req;
  logic [7:0]  p1_addr;
  logic        coll_clr;

  logic        a_p0_rvalid, b_p0_rvalid;
  logic [31:0] a_p0_rdata,  b_p0_rdata;
  logic        a_p1_rvalid, b_p1_rvalid;
  logic [31:0] a_p1_rdata,  b_p1_rdata;
  logic [15:0] a_coll_cnt,  b_coll_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] coll_exp;

  always #5 CLK = ~CLK;

  sram_1rw1r_param #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(1)
  ) u1 (
    .CLK(CLK), .RESET(RESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .coll_clr(coll_clr), .coll_cnt(a_coll_cnt)
  );

  sram_1rw1r_param #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(2)
  ) u2 (
    .CLK(CLK), .RESET(RESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .coll_clr(coll_clr), .coll_cnt(b_coll_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_be = 4'h0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_addr = 0; coll_clr = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    p0_req = 1; p0_we = 1; p0_be = be; p0_addr = a; p0_wdata = d;
  endtask

  initial begin
`ifdef SRAM_BYPASS_EN
    coll_exp = 32'h12345678;
`else
    coll_exp = 32'h00000000;
`endif
    idle();
    RESET = 1;
    tick();
    tick();
    chk("rst_a_p0v", 32'(a_p0_rvalid), 0);
    chk("rst_a_p1v", 32'(a_p1_rvalid), 0);
    chk("rst_a_p0d", a_p0_rdata, 0);
    chk("rst_a_p1d", a_p1_rdata, 0);
    chk("rst_a_cnt", 32'(a_coll_cnt), 0);
    chk("rst_b_p1v", 32'(b_p1_rvalid), 0);
    chk("rst_b_p1d", b_p1_rdata, 0);
    RESET = 0;
    tick();

    // Basic write then port-1 read, both latencies
    wr(8'h10, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    chk("wr_no_rv_a", 32'(a_p0_rvalid), 0);
    p1_req = 1; p1_addr = 8'h10;
    tick();
    idle();
    chk("lat1_v", 32'(a_p1_rvalid), 1);
    chk("lat1_d", a_p1_rdata, 32'hDEADBEEF);
    chk("lat2_v_early", 32'(b_p1_rvalid), 0);
    tick();
    chk("lat1_v_pulse", 32'(a_p1_rvalid), 0);
    chk("lat1_d_hold", a_p1_rdata, 32'hDEADBEEF);
    chk("lat2_v", 32'(b_p1_rvalid), 1);
    chk("lat2_d", b_p1_rdata, 32'hDEADBEEF);
    tick();
    chk("lat2_v_pulse", 32'(b_p1_rvalid), 0);

    // Byte enables
    wr(8'd5, 32'h11223344, 4'hF);
    tick();
    wr(8'd5, 32'hAABBCCDD, 4'b0101);
    tick();
    idle();
    p0_req = 1; p0_addr = 8'd5;
    tick();
    idle();
    chk("be_a_v", 32'(a_p0_rvalid), 1);
    chk("be_a_d", a_p0_rdata, 32'h11BB33DD);
    tick();
    chk("be_b_d", b_p0_rdata, 32'h11BB33DD);
    chk("be_b_v", 32'(b_p0_rvalid), 1);

    // be=0 write is a no-op and not a collision
    wr(8'd5, 32'h00000000, 4'h0);
    p1_req = 1; p1_addr = 8'd5;
    tick();
    idle();
    chk("be0_d", a_p1_rdata, 32'h11BB33DD);
    chk("be0_cnt", 32'(a_coll_cnt), 0);

    // Collision
    wr(8'd7, 32'h0, 4'hF);
    tick();
    wr(8'd7, 32'h12345678, 4'hF);
    p1_req = 1; p1_addr = 8'd7;
    tick();
    idle();
    chk("coll_a_d", a_p1_rdata, coll_exp);
    chk("coll_a_cnt", 32'(a_coll_cnt), 1);
    chk("coll_b_cnt", 32'(b_coll_cnt), 1);
    tick();
    chk("coll_b_d", b_p1_rdata, coll_exp);

    // p0 and p1 reading the same word: no collision
    p0_req = 1; p0_addr = 8'd7;
    p1_req = 1; p1_addr = 8'd7;
    tick();
    idle();
    chk("rr_p0", a_p0_rdata, 32'h12345678);
    chk("rr_p1", a_p1_rdata, 32'h12345678);
    chk("rr_cnt", 32'(a_coll_cnt), 1);

    // Out of range on u1 (DEPTH=200)
    wr(8'd199, 32'h0BADF00D, 4'hF);
    tick();
    wr(8'd210, 32'hFFFFFFFF, 4'hF);
    tick();
    idle();
    p0_req = 1; p0_addr = 8'd199;
    p1_req = 1; p1_addr = 8'd210;
    tick();
    idle();
    chk("oor_v", 32'(a_p1_rvalid), 1);
    chk("oor_d", a_p1_rdata, 0);
    chk("oor_199", a_p0_rdata, 32'h0BADF00D);
    tick();
    chk("inr_b_210", b_p1_rdata, 32'hFFFFFFFF);

    // Saturation and clear
    coll_clr = 1;
    tick();
    idle();
    chk("clr_cnt", 32'(a_coll_cnt), 0);
    wr(8'd7, 32'h12345678, 4'hF);
    p1_req = 1; p1_addr = 8'd7;
    repeat (65534) tick();
    chk("sat_fffe", 32'(a_coll_cnt), 32'hFFFE);
    repeat (6) tick();
    chk("sat_a", 32'(a_coll_cnt), 32'hFFFF);
    chk("sat_b", 32'(b_coll_cnt), 32'hFFFF);
    coll_clr = 1;
    tick();
    idle();
    chk("clr_prio_a", 32'(a_coll_cnt), 0);
    chk("clr_prio_b", 32'(b_coll_cnt), 0);
    tick();
    tick();

    // Reset during an in-flight RD_LAT=2 read
    p1_req = 1; p1_addr = 8'h10;
    tick();
    idle();
    RESET = 1;
    #1;
    chk("mid_b_v0", 32'(b_p1_rvalid), 0);
    chk("mid_b_d0", b_p1_rdata, 0);
    chk("mid_a_v0", 32'(a_p1_rvalid), 0);
    tick();
    chk("mid_b_v1", 32'(b_p1_rvalid), 0);
    chk("mid_b_d1", b_p1_rdata, 0);
    RESET = 0;
    tick();
    chk("mid_b_v2", 32'(b_p1_rvalid), 0);
    chk("mid_b_d2", b_p1_rdata, 0);
    p1_req = 1; p1_addr = 8'h10;
    tick();
    idle();
    chk("post_a_v", 32'(a_p1_rvalid), 1);
    chk("post_a_d", a_p1_rdata, 32'hDEADBEEF);
    tick();
    chk("post_b_v", 32'(b_p1_rvalid), 1);
    chk("post_b_d", b_p1_rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
